lfsr8_e: RTL and testbench

LFSR8_E -- requirements
Module: lfsr8_e

---
 rtl/lfsr8_e.sv | 42 ++++
 tb/tb_lfsr8_e.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/lfsr8_e.sv
// 8-bit Fibonacci LFSR, polynomial x^8+x^6+x^5+x^4+1 (period 255).
// Steps once per enabled clock edge; an all-zero state recovers to SEED.
module lfsr8_e #(
    parameter logic [7:0] SEED = 8'h01
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enb,
    output logic [7:0] q
);

    logic [7:0] q_r;
    logic [7:0] q_next_s;

    function automatic logic fb_calc(input logic [7:0] s);
        return s[7] ^ s[5] ^ s[4] ^ s[3];
    endfunction

    // Next-state: shift toward MSB, or escape the all-zero lock-up state
    always_comb begin
        q_next_s = q_r;
        if (q_r == 8'h00) begin
            q_next_s = SEED;
        end else begin
            q_next_s = {q_r[6:0], fb_calc(q_r)};
        end
    end

    // State register: async reset to SEED, advance only when enabled
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q_r <= SEED;
        end else if (enb) begin
            q_r <= q_next_s;
        end else begin
            q_r <= q_r;
        end
    end

    assign q = q_r;

endmodule

// File: tb/tb_lfsr8_e.sv
// Self-checking bench for lfsr8_e: vector table plus hand-written
// multi-cycle sequences, with expected values queued at drive time.
module tb_lfsr8_e;

    logic       clk;
    logic       rst;
    logic       enb;
    logic [7:0] q;

    int n_checks = 0;
    int n_fail   = 0;
    logic [7:0] exp_q[$];

    typedef struct {
        logic       rst;
        logic       enb;
        logic [7:0] exp;
        string      name;
    } vec_t;

    vec_t vecs[11];

    lfsr8_e #(.SEED(8'h01)) dut (
        .clk(clk),
        .rst(rst),
        .enb(enb),
        .q  (q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] model_next(input logic [7:0] s);
        if (s == 8'h00) return 8'h01;
        return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %02h, expected %02h at %0t", name, act, req, $time);
        end
    endtask

    // Drive enb, queue the expected post-edge value, then compare after the edge
    task automatic cycle(input logic e, input logic [7:0] exp, input string name);
        enb = e;
        exp_q.push_back(exp);
        @(posedge clk);
        #1;
        check(name, q, exp_q.pop_front());
    endtask

    task automatic do_reset();
        enb = 1'b0;
        rst = 1'b0;
        #1;
        check("reset_async", q, 8'h01);
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] st;
        bit         seen[256];

        vecs[0]  = '{1'b0, 1'b0, 8'h01, "rst_hold"};
        vecs[1]  = '{1'b0, 1'b1, 8'h01, "rst_enb"};
        vecs[2]  = '{1'b1, 1'b0, 8'h01, "release_hold"};
        vecs[3]  = '{1'b1, 1'b1, 8'h02, "step1"};
        vecs[4]  = '{1'b1, 1'b1, 8'h04, "step2"};
        vecs[5]  = '{1'b1, 1'b1, 8'h08, "step3"};
        vecs[6]  = '{1'b1, 1'b1, 8'h11, "step4"};
        vecs[7]  = '{1'b1, 1'b1, 8'h23, "step5"};
        vecs[8]  = '{1'b1, 1'b1, 8'h47, "step6"};
        vecs[9]  = '{1'b1, 1'b1, 8'h8E, "step7"};
        vecs[10] = '{1'b1, 1'b0, 8'h8E, "hold_after7"};

        // Start deasserted so the first assertion is a real falling edge
        rst = 1'b1;
        enb = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        check("reset_immediate", q, 8'h01);

        // Table-driven reset, release and first steps
        for (int i = 0; i < 11; i++) begin
            rst = vecs[i].rst;
            cycle(vecs[i].enb, vecs[i].exp, vecs[i].name);
        end

        // Full period: no zero, no repeat, back to 01 after 255 steps
        do_reset();
        st = 8'h01;
        for (int i = 0; i < 256; i++) seen[i] = 1'b0;
        seen[1] = 1'b1;
        for (int i = 0; i < 255; i++) begin
            st = model_next(st);
            cycle(1'b1, st, "period_step");
            if (i < 254) begin
                check("period_nonzero", {7'd0, (q == 8'h00)}, 8'h00);
                check("period_unique", {7'd0, seen[q]}, 8'h00);
                seen[q] = 1'b1;
            end
        end
        check("period_wrap", q, 8'h01);

        // Hold: 20 steps, 10 disabled cycles, then resume
        do_reset();
        st = 8'h01;
        for (int i = 0; i < 20; i++) begin
            st = model_next(st);
            cycle(1'b1, st, "hold_pre");
        end
        for (int i = 0; i < 10; i++) cycle(1'b0, st, "hold_const");
        st = model_next(st);
        cycle(1'b1, st, "hold_resume");

        // enb pulse between edges has no effect at the next edge
        enb = 1'b1;
        #2;
        cycle(1'b0, st, "enb_glitch");

        // Interleaved disabled cycles keep sequence order
        for (int i = 0; i < 8; i++) begin
            if (i % 2 == 0) st = model_next(st);
            cycle((i % 2 == 0), st, "interleave");
        end

        // Async reset mid-run with enb=1
        for (int i = 0; i < 3; i++) begin
            st = model_next(st);
            cycle(1'b1, st, "midrun_pre");
        end
        rst = 1'b0;
        #1;
        check("midrun_async", q, 8'h01);
        cycle(1'b1, 8'h01, "midrun_rst_edge");
        rst = 1'b1;
        cycle(1'b1, 8'h02, "midrun_first_step");

        // Lock-up: zero state holds when disabled, recovers to SEED when enabled
        dut.q_r = 8'h00;
        cycle(1'b0, 8'h00, "lockup_hold");
        cycle(1'b0, 8'h00, "lockup_hold2");
        cycle(1'b1, 8'h01, "lockup_recover");
        cycle(1'b1, 8'h02, "lockup_next");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
